sw_debounce: RTL
================

Name: sw_debounce

Overview:
- Conditions the raw board switch bank before it reaches the design's `sw` input.
- Per-bit chain: two-flop synchronizer, then a saturating stability counter; a bit's clean value changes only after the synchronized input has differed from it for STABLE_CYCLES consecutive clocks.
- Also emits one-cycle rise/fall/changed pulses so downstream logic can react to edges without its own edge detectors.
- Runs on the undivided board clock, upstream of the clock divider domain.

Parameters:
- WIDTH, 9, number of switch bits conditioned independently.
- STABLE_CYCLES, 500_000, consecutive mismatching cycles required before a clean bit updates; legal range 1 .. 2^CNT_WIDTH - 1.
- CNT_WIDTH, 19, width of each per-bit stability counter; must hold STABLE_CYCLES-1.

Ports:
- clk  input  1  board clock.
- rst_n  input  1  asynchronous active-low reset.
- sw_raw  input  WIDTH  raw, asynchronous, bouncing switch levels.
- sw_clean  output  WIDTH  debounced, registered switch levels.
- rise  output  WIDTH  per-bit one-cycle pulse when sw_clean bit goes 0->1.
- fall  output  WIDTH  per-bit one-cycle pulse when sw_clean bit goes 1->0.
- changed  output  1  one-cycle pulse, OR of all rise and fall bits, same cycle.

Behaviour:
- Reset (rst_n low, async): sync stage 1 and stage 2, all counters, sw_clean, rise, fall and changed clear to 0 immediately. The clean state is held while rst_n is low.
- Synchronizer: at each posedge, s1 <= sw_raw and s2 <= s1. Only s2 is used downstream. There is no combinational path from sw_raw to any output.
- Per bit i, at each posedge:
  - If s2[i] == sw_clean[i]: cnt[i] <= 0.
  - Else if cnt[i] == STABLE_CYCLES-1: sw_clean[i] <= s2[i], cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i] + 1.
- Latency: a raw level held stable from before edge k appears on sw_clean after edge k+1+STABLE_CYCLES, i.e. 2 sync edges plus STABLE_CYCLES counting edges, the last of which updates.
- Bounce: any single cycle where s2[i] equals sw_clean[i] restarts that bit's count from 0. A glitch shorter than STABLE_CYCLES never reaches sw_clean.
- Pulses: rise[i] is 1 for exactly the cycle after the edge where sw_clean[i] updated 0->1, and 0 otherwise; fall[i] likewise for 1->0. Pulses are registered, and changed is registered alongside them.
- Bits are fully independent: several bits may update on the same edge, each producing its own pulse; changed is then a single 1-cycle pulse.
- STABLE_CYCLES = 1: a clean bit follows s2 with 1 edge delay and there is no filtering. This is legal and used in simulation.
- Counter never exceeds STABLE_CYCLES-1, so there is no wrap-around.
- Reset mid-count: the count is discarded and sw_clean returns to 0. After release, a held switch of 1 re-qualifies over the full latency and produces a rise pulse.
- No other state; no handshake. Downstream logic samples sw_clean directly.

Test Plan:
- Use WIDTH=9, STABLE_CYCLES=4 throughout.
- Reset: hold rst_n=0 with sw_raw=9'h1FF -> sw_clean=0, rise=fall=0, changed=0. Assert rst_n mid-cycle -> outputs clear without waiting for a clock edge.
- Clean step: sw_raw 0->9'h001, held -> sw_clean[0]=1 after edge 6 counted from the first sampling edge; rise[0] and changed high exactly one cycle; fall=0.
- Bounce rejection: bit 3 toggles 1,0,1,0 every 2 cycles, then holds 1 -> sw_clean[3] stays 0 during bouncing and becomes 1 exactly 6 edges after the final transition; single rise[3] pulse.
- Simultaneous: bits 0 and 8 fall while bit 5 rises on the same raw edge -> one common update edge; fall=9'h101, rise=9'h020, changed is a single 1-cycle pulse.
- Reset mid-operation: bit 2 high for 3 cycles, then rst_n pulsed low, then released with bit 2 still high -> sw_clean[2]=0 through reset; rise[2] occurs only after the full 6-edge latency measured from release.
- STABLE_CYCLES=1 build: a 1-cycle high glitch on sw_raw[1] -> sw_clean[1] shows a 1-cycle high, with matching rise then fall pulses.

Source files
------------

// File: rtl/sw_debounce.sv
// Switch-bank conditioner: per-bit two-flop synchronizer followed by a
// saturating stability counter. A clean bit flips only after its synchronized
// input has disagreed with it for STABLE_CYCLES consecutive clocks. Registered
// rise/fall/changed pulses accompany every clean-level update.
module sw_debounce #(
   parameter int WIDTH         = 9,
   parameter int STABLE_CYCLES = 500_000,
   parameter int CNT_WIDTH     = 19
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_raw,
   output logic [WIDTH-1:0] sw_clean,
   output logic [WIDTH-1:0] rise,
   output logic [WIDTH-1:0] fall,
   output logic             changed
);

   // Terminal count: the edge that sees this value while still mismatching
   // is the STABLE_CYCLES-th mismatching edge and performs the update.
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STABLE_CYCLES - 1);

   logic [WIDTH-1:0]     s1_r;
   logic [WIDTH-1:0]     s2_r;
   logic [WIDTH-1:0]     clean_r;
   logic [WIDTH-1:0]     rise_r;
   logic [WIDTH-1:0]     fall_r;
   logic                 changed_r;
   logic [CNT_WIDTH-1:0] cnt_r      [WIDTH];

   logic [WIDTH-1:0]     clean_next_s;
   logic [CNT_WIDTH-1:0] cnt_next_s [WIDTH];

   // Two-flop synchronizer; only the second stage feeds the filter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_r <= '0;
         s2_r <= '0;
      end else begin
         s1_r <= sw_raw;
         s2_r <= s1_r;
      end
   end

   // Next-state of each bit's stability counter and clean level.
   always_comb begin
      clean_next_s = clean_r;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_next_s[i] = '0;
         if (s2_r[i] == clean_r[i]) begin
            // Agreement (or a bounce back) restarts qualification.
            cnt_next_s[i] = '0;
         end else if (cnt_r[i] == CNT_MAX) begin
            clean_next_s[i] = s2_r[i];
            cnt_next_s[i]   = '0;
         end else begin
            cnt_next_s[i] = cnt_r[i] + CNT_WIDTH'(1);
         end
      end
   end

   // Counter and clean-level registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clean_r <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         clean_r <= clean_next_s;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
      end
   end

   // Edge pulses, registered on the same edge that updates the clean level so
   // they are visible exactly during the cycle following that update.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rise_r    <= '0;
         fall_r    <= '0;
         changed_r <= 1'b0;
      end else begin
         rise_r    <= clean_next_s & ~clean_r;
         fall_r    <= ~clean_next_s & clean_r;
         changed_r <= |(clean_next_s ^ clean_r);
      end
   end

   assign sw_clean = clean_r;
   assign rise     = rise_r;
   assign fall     = fall_r;
   assign changed  = changed_r;

endmodule
